// File: rtl/axis_red_pitaya_adc_framer.sv
// Two-channel ADC capture framed into AXI4-Stream beats through a small output FIFO.
// Define AXIS_RED_PITAYA_ADC_FRAMER_OVF_CNT_EN to build the dropped-sample counter.
module axis_red_pitaya_adc_framer #(
    parameter int unsigned ADC_DATA_WIDTH = 14,
    parameter int unsigned CNT_WIDTH      = 16,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [ADC_DATA_WIDTH-1:0] adc_dat_0,
    input  logic [ADC_DATA_WIDTH-1:0] adc_dat_1,
    input  logic                      arm,
    input  logic                      trigger,
    input  logic [CNT_WIDTH-1:0]      frame_len,
    input  logic                      clr_ovf,
    output logic [31:0]               m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic                      busy,
    output logic                      overflow,
    output logic [CNT_WIDTH-1:0]      ovf_cnt
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned EW = 33;
    localparam logic [31:0] MARKER = 32'h8000_8000;

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, FLUSH} state_e;

    state_e                    state_q, state_d;
    logic [CNT_WIDTH-1:0]      len_q, len_d;
    logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
    logic                      s1_vld_q, s1_vld_d;
    logic                      s1_last_q, s1_last_d;
    logic [ADC_DATA_WIDTH-1:0] s1_dat0_q, s1_dat1_q;
    logic                      busy_q;

    logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [EW-1:0]             mem_q [FIFO_DEPTH];
    logic                      full, wr_en, rd_en, drop, head_bypass, tvalid_d;
    logic [EW-1:0]             wr_entry, head_d;
    logic                      tvalid_q, tlast_q;
    logic [31:0]               tdata_q;
    logic                      overflow_q;

    // Frame sequencing runs on input cycles; valid/last flags travel with the S1 sample.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            s1_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
            s1_dat0_q <= '0;
            s1_dat1_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            s1_vld_q  <= s1_vld_d;
            s1_last_q <= s1_last_d;
            s1_dat0_q <= adc_dat_0;
            s1_dat1_q <= adc_dat_1;
            busy_q    <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        s1_vld_d  = 1'b0;
        s1_last_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A dropped closing sample lands here one cycle after capture ends.
                if (drop && s1_last_q) begin
                    state_d = FLUSH;
                end else if (arm && (frame_len != '0)) begin
                    state_d = ARMED;
                    len_d   = frame_len;
                end
            end
            ARMED: begin
                if (trigger) begin
                    s1_vld_d  = 1'b1;
                    cnt_d     = CNT_WIDTH'(1);
                    s1_last_d = (len_q == CNT_WIDTH'(1));
                    state_d   = s1_last_d ? IDLE : CAPTURE;
                end
            end
            CAPTURE: begin
                s1_vld_d = 1'b1;
                cnt_d    = cnt_q + CNT_WIDTH'(1);
                if (cnt_d == len_q) begin
                    s1_last_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            FLUSH: begin
                if (!full) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO write/read decisions use pointer state from the start of the cycle.
    assign full = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_en = tvalid_q && m_axis_tready;

    always_comb begin
        wr_en    = 1'b0;
        drop     = 1'b0;
        wr_entry = {s1_last_q, 16'($signed(s1_dat1_q)), 16'($signed(s1_dat0_q))};
        if (state_q == FLUSH) begin
            wr_en    = !full;
            wr_entry = {1'b1, MARKER};
        end else if (s1_vld_q) begin
            wr_en = !full;
            drop  = full;
        end
    end

    assign wr_ptr_d    = wr_ptr_q + PW'(wr_en);
    assign rd_ptr_d    = rd_ptr_q + PW'(rd_en);
    assign tvalid_d    = (wr_ptr_d != rd_ptr_d);
    assign head_bypass = wr_en && (wr_ptr_q == rd_ptr_d);
    assign head_d      = head_bypass ? wr_entry : mem_q[rd_ptr_d[AW-1:0]];

    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
        end
    end

    // Output beat is a registered copy of the next FIFO head.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            tvalid_q <= tvalid_d;
            if (tvalid_d) begin
                {tlast_q, tdata_q} <= head_d;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= clr_ovf ? drop : (overflow_q | drop);
        end
    end

`ifdef AXIS_RED_PITAYA_ADC_FRAMER_OVF_CNT_EN
    logic [CNT_WIDTH-1:0] ovf_cnt_q;

    // Saturating count of dropped samples; a same-cycle drop wins over clear.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ovf_cnt_q <= '0;
        end else if (clr_ovf) begin
            ovf_cnt_q <= CNT_WIDTH'(drop);
        end else if (drop && (ovf_cnt_q != '1)) begin
            ovf_cnt_q <= ovf_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign ovf_cnt = ovf_cnt_q;
`else
    assign ovf_cnt = '0;
`endif

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = busy_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_axis_red_pitaya_adc_framer.sv
// Scoreboard bench for axis_red_pitaya_adc_framer: expected beats queued at stimulus time.
module tb_axis_red_pitaya_adc_framer;

    localparam int unsigned W     = 14;
    localparam int unsigned CW    = 16;
    localparam int unsigned DEPTH = 4;
`ifdef AXIS_RED_PITAYA_ADC_FRAMER_OVF_CNT_EN
    localparam logic [CW-1:0] OVF4 = 16'd4;
    localparam logic [CW-1:0] OVF1 = 16'd1;
`else
    localparam logic [CW-1:0] OVF4 = 16'd0;
    localparam logic [CW-1:0] OVF1 = 16'd0;
`endif

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [W-1:0]  adc_dat_0, adc_dat_1;
    logic          arm, trigger, clr_ovf;
    logic [CW-1:0] frame_len;
    logic [31:0]   m_axis_tdata;
    logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic          busy, overflow;
    logic [CW-1:0] ovf_cnt;

    always #5 aclk = ~aclk;

    axis_red_pitaya_adc_framer #(
        .ADC_DATA_WIDTH(W),
        .CNT_WIDTH     (CW),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .adc_dat_0    (adc_dat_0),
        .adc_dat_1    (adc_dat_1),
        .arm          (arm),
        .trigger      (trigger),
        .frame_len    (frame_len),
        .clr_ovf      (clr_ovf),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .busy         (busy),
        .overflow     (overflow),
        .ovf_cnt      (ovf_cnt)
    );

    logic [32:0] sb [$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [W-1:0] ramp = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] sx(input logic [W-1:0] d);
        return {{(16 - W){d[W-1]}}, d};
    endfunction

    // Advance one cycle and present the next ramp sample pair.
    task automatic tick();
        @(posedge aclk);
        #1;
        adc_dat_0 = ramp;
        adc_dat_1 = ramp ^ 14'h2AAA;
        ramp      = ramp + 14'd1;
    endtask

    task automatic push_cur(input logic last);
        sb.push_back({last, sx(adc_dat_1), sx(adc_dat_0)});
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        tick();
        tick();
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    // Output monitor: pops expected beats and checks stall stability.
    logic [32:0] prev_beat;
    logic        prev_stall = 1'b0;
    always @(negedge aclk) begin : mon
        logic [32:0] e;
        if (!aresetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_tvalid", 64'(m_axis_tvalid), 64'd1);
                check("hold_beat", 64'({m_axis_tlast, m_axis_tdata}), 64'(prev_beat));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat_sb_size", 64'(sb.size()), 64'd1);
                end else begin
                    e = sb.pop_front();
                    check("beat", 64'({m_axis_tlast, m_axis_tdata}), 64'(e));
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_beat  = {m_axis_tlast, m_axis_tdata};
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        aresetn = 1'b1; arm = 1'b0; trigger = 1'b0; clr_ovf = 1'b0;
        frame_len = '0; m_axis_tready = 1'b1; adc_dat_0 = '0; adc_dat_1 = '0;
        #2 aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tlast", 64'(m_axis_tlast), 64'd0);
        check("rst_tdata", 64'(m_axis_tdata), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_ovf_cnt", 64'(ovf_cnt), 64'd0);
        tick(); aresetn = 1'b1;
        tick(); tick();

        // Basic frame of 4 with latency and busy timing
        arm = 1'b1; frame_len = 16'd4;
        tick(); arm = 1'b0;
        tick(); tick();
        trigger = 1'b1; push_cur(1'b0);
        @(negedge aclk);
        check("lat_t0_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("busy_armed", 64'(busy), 64'd1);
        tick(); trigger = 1'b0; push_cur(1'b0);
        @(negedge aclk);
        check("lat_t1_tvalid", 64'(m_axis_tvalid), 64'd0);
        tick(); push_cur(1'b0);
        @(negedge aclk);
        check("lat_t2_tvalid", 64'(m_axis_tvalid), 64'd1);
        tick(); push_cur(1'b1);
        @(negedge aclk);
        check("busy_t3", 64'(busy), 64'd1);
        tick();
        @(negedge aclk);
        check("busy_t4", 64'(busy), 64'd0);
        wait_drain("drain_frame4", 20);

        // Sign extension of a single-sample frame
        arm = 1'b1; frame_len = 16'd1;
        tick(); arm = 1'b0;
        tick();
        trigger = 1'b1; adc_dat_0 = 14'h2000; adc_dat_1 = 14'h1FFF;
        sb.push_back({1'b1, 32'h1FFF_E000});
        tick(); trigger = 1'b0;
        @(negedge aclk);
        check("busy_len1_done", 64'(busy), 64'd0);
        wait_drain("drain_sext", 20);

        // Overflow with stalled sink, closing sample dropped -> marker
        m_axis_tready = 1'b0; arm = 1'b1; frame_len = 16'd8;
        tick(); arm = 1'b0;
        tick();
        trigger = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i < DEPTH) push_cur(1'b0);
            tick(); trigger = 1'b0;
        end
        tick();
        @(negedge aclk);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_cnt_4", 64'(ovf_cnt), 64'(OVF4));
        check("busy_flush", 64'(busy), 64'd1);
        check("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
        sb.push_back({1'b1, 32'h8000_8000});
        tick(); m_axis_tready = 1'b1;
        wait_drain("drain_marker", 30);
        @(negedge aclk);
        check("busy_after_flush", 64'(busy), 64'd0);
        check("ovf_sticky", 64'(overflow), 64'd1);

        // Clear coincident with a drop
        m_axis_tready = 1'b0; arm = 1'b1; frame_len = 16'd5;
        tick(); arm = 1'b0;
        tick();
        trigger = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < DEPTH) push_cur(1'b0);
            tick(); trigger = 1'b0;
        end
        clr_ovf = 1'b1;
        tick(); clr_ovf = 1'b0;
        @(negedge aclk);
        check("clr_drop_flag", 64'(overflow), 64'd1);
        check("clr_drop_cnt", 64'(ovf_cnt), 64'(OVF1));
        sb.push_back({1'b1, 32'h8000_8000});
        tick(); m_axis_tready = 1'b1;
        wait_drain("drain_clr_drop", 30);
        clr_ovf = 1'b1;
        tick(); clr_ovf = 1'b0;
        @(negedge aclk);
        check("clr_flag", 64'(overflow), 64'd0);
        check("clr_cnt", 64'(ovf_cnt), 64'd0);

        // Ignored arms: zero length, and arm during capture
        frame_len = '0; arm = 1'b1;
        tick(); arm = 1'b0;
        @(negedge aclk);
        check("arm_len0_busy", 64'(busy), 64'd0);
        tick(); trigger = 1'b1;
        tick(); trigger = 1'b0;
        tick();
        @(negedge aclk);
        check("arm_len0_tvalid", 64'(m_axis_tvalid), 64'd0);
        frame_len = 16'd3; arm = 1'b1;
        tick(); arm = 1'b0;
        tick();
        trigger = 1'b1; push_cur(1'b0);
        tick(); trigger = 1'b0; frame_len = 16'd5; arm = 1'b1; push_cur(1'b0);
        tick(); arm = 1'b0; push_cur(1'b1);
        tick();
        @(negedge aclk);
        check("busy_after_ignored_arm", 64'(busy), 64'd0);
        tick(); trigger = 1'b1;
        tick(); tick(); trigger = 1'b0;
        @(negedge aclk);
        check("no_rearm_busy", 64'(busy), 64'd0);
        wait_drain("drain_ignored_arm", 20);

        // Reset mid-capture with 3 beats queued
        m_axis_tready = 1'b0; frame_len = 16'd8; arm = 1'b1;
        tick(); arm = 1'b0;
        tick();
        trigger = 1'b1; push_cur(1'b0);
        tick(); trigger = 1'b0; push_cur(1'b0);
        tick(); push_cur(1'b0);
        tick(); tick();
        @(negedge aclk);
        check("pre_rst_tvalid", 64'(m_axis_tvalid), 64'd1);
        check("pre_rst_busy", 64'(busy), 64'd1);
        @(posedge aclk);
        #1 aresetn = 1'b0;
        sb.delete();
        #1;
        check("async_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        tick(); tick();
        aresetn = 1'b1; m_axis_tready = 1'b1;
        repeat (5) begin
            tick(); trigger = 1'b1;
        end
        trigger = 1'b0;
        tick();
        @(negedge aclk);
        check("post_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("post_rst_busy", 64'(busy), 64'd0);
        frame_len = 16'd2; arm = 1'b1;
        tick(); arm = 1'b0;
        tick();
        trigger = 1'b1; push_cur(1'b0);
        tick(); trigger = 1'b0; push_cur(1'b1);
        tick();
        wait_drain("drain_post_rst", 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
